// File: rtl/hazard_resolver_mlane_if.sv
// Signal bundle between issue-stage hazard detectors and the multi-lane hazard resolver.
// The master side drives detector inputs; the slave side (resolver) drives pipeline controls.
interface hazard_resolver_mlane_if #(
    parameter int unsigned LANES = 2
);
    logic [LANES-1:0] data_haz;
    logic [LANES-1:0] fwd_ok;
    logic             str_haz;
    logic             ctrl_haz;
    logic             br_resolved;
    logic             br_correct;
    logic [LANES-1:0] lane_stall;
    logic [LANES-1:0] fwd_sel;
    logic             flush_o;
    logic             tmo_o;
    logic [2:0]       state_o;
    logic [15:0]      stall_cnt;
    logic [7:0]       flush_cnt;

    modport master (
        output data_haz, fwd_ok, str_haz, ctrl_haz, br_resolved, br_correct,
        input  lane_stall, fwd_sel, flush_o, tmo_o, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  data_haz, fwd_ok, str_haz, ctrl_haz, br_resolved, br_correct,
        output lane_stall, fwd_sel, flush_o, tmo_o, state_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_resolver_mlane.sv
// Multi-lane hazard resolver: per-lane stall/forward selects and global flush for an in-order
// issue group, with branch-resolve timeout, data-stall cap and saturating perf counters.
module hazard_resolver_mlane #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned STALL_MAX = 4,
    parameter int unsigned BR_TMO    = 8,
    parameter int unsigned FLUSH_CYC = 1
) (
    input logic                    clk,
    input logic                    rst,
    hazard_resolver_mlane_if.slave bus
);
    localparam int unsigned MaxAb  = (STALL_MAX > BR_TMO) ? STALL_MAX : BR_TMO;
    localparam int unsigned MaxCyc = (MaxAb > FLUSH_CYC) ? MaxAb : FLUSH_CYC;
    localparam int unsigned TmrW   = $clog2(MaxCyc + 1);

    localparam logic [TmrW-1:0]  BrLast    = TmrW'(BR_TMO - 1);
    localparam logic [TmrW-1:0]  StallLast = TmrW'(STALL_MAX - 1);
    localparam logic [TmrW-1:0]  FlushLast = TmrW'(FLUSH_CYC - 1);
    localparam logic [LANES-1:0] LaneOne   = LANES'(1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCwait  = 3'd1,
        StDstall = 3'd2,
        StSstall = 3'd3,
        StFlush  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [LANES-1:0] stall_q, stall_d;
    logic [LANES-1:0] fwd_q, fwd_d;
    logic             flush_q, flush_d;
    logic             tmo_q, tmo_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic [7:0]       flush_cnt_q, flush_cnt_d;

    logic             mis, ok, pend, restart;
    logic [LANES-1:0] u, u_low, stall_mask;

    always_comb begin
        mis  = bus.ctrl_haz & bus.br_resolved & ~bus.br_correct;
        ok   = bus.ctrl_haz & bus.br_resolved & bus.br_correct;
        pend = bus.ctrl_haz & ~bus.br_resolved;
        u    = bus.data_haz & ~bus.fwd_ok;
        // Isolate the oldest stalled lane; every lane from there upward must hold.
        u_low      = u & (~u + LaneOne);
        stall_mask = ~(u_low - LaneOne);
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        fwd_d   = '0;
        tmo_d   = 1'b0;
        stall_d = '0;
        flush_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mis)            state_d = StFlush;
                else if (pend)      state_d = StCwait;
                else if (|u)        state_d = StDstall;
                else if (bus.str_haz) state_d = StSstall;
                else                fwd_d = bus.data_haz & bus.fwd_ok;
            end
            StCwait: begin
                if (mis)                           state_d = StFlush;
                else if (ok || !bus.ctrl_haz)      state_d = StIdle;
                else if (tmr_q == BrLast) begin
                    state_d = StFlush;
                    tmo_d   = 1'b1;
                end
            end
            StDstall: begin
                if (mis)       state_d = StFlush;
                else if (pend) state_d = StCwait;
                else if (u == '0) state_d = bus.str_haz ? StSstall : StIdle;
                else if (tmr_q == StallLast) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                    fwd_d   = bus.data_haz;
                end
            end
            StSstall: begin
                if (mis)               state_d = StFlush;
                else if (pend)         state_d = StCwait;
                else if (!bus.str_haz) state_d = (|u) ? StDstall : StIdle;
            end
            StFlush: begin
                if (mis)                     restart = 1'b1;
                else if (tmr_q == FlushLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if ((state_d != state_q) || restart) tmr_d = '0;
        else if (&tmr_q)                     tmr_d = tmr_q;
        else                                 tmr_d = tmr_q + TmrW'(1);

        case (state_d)
            StCwait, StSstall: stall_d = '1;
            StDstall:          stall_d = stall_mask;
            StFlush:           flush_d = 1'b1;
            default:           stall_d = '0;
        endcase

        stall_cnt_d = stall_cnt_q;
        if ((|stall_d) && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;

        flush_cnt_d = flush_cnt_q;
        if (((state_d == StFlush) && (state_q != StFlush)) || restart) begin
            if (flush_cnt_q != 8'hFF) flush_cnt_d = flush_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            stall_q     <= '0;
            fwd_q       <= '0;
            flush_q     <= 1'b0;
            tmo_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            stall_q     <= stall_d;
            fwd_q       <= fwd_d;
            flush_q     <= flush_d;
            tmo_q       <= tmo_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.lane_stall = stall_q;
    assign bus.fwd_sel    = fwd_q;
    assign bus.flush_o    = flush_q;
    assign bus.tmo_o      = tmo_q;
    assign bus.state_o    = state_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
endmodule
